// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD request arbiter.
//
// Contents:
//   arb_state_t            - arbiter FSM states (IDLE, ISSUE, BUSY, RELEASE)
//   NREQ_DEFAULT           - default number of requesters
//   ISSUE_TIMEOUT_DEFAULT  - default cycles allowed for sd_busy to rise
//   SLOT_*                 - fixed requester slot indices
//   idx_width()            - index width helper (never narrower than 1 bit)
package sd_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_BUSY    = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_t;

   localparam int NREQ_DEFAULT          = 3;
   localparam int ISSUE_TIMEOUT_DEFAULT = 1024;

   localparam int SLOT_C1541  = 0;
   localparam int SLOT_LOADER = 1;
   localparam int SLOT_SPARE  = 2;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//
// Ports:
//   i_req         in  NREQ  request vector
//   i_last_grant  in  IDXW  index of the slot granted last
//   o_winner      out NREQ  one-hot winner, zero when nothing is requested
//   o_valid       out 1     at least one request is present
//
// Search starts at i_last_grant+1 and wraps modulo NREQ.
module rr_pick
   import sd_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEFAULT,
   parameter int IDXW = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDXW-1:0] i_last_grant,
   output logic [NREQ-1:0] o_winner,
   output logic            o_valid
);

   int w_dist;
   int w_best_dist;
   int w_best_idx;

   // Rank each requesting slot by its distance after last_grant;
   // distance 0 is the slot immediately following last_grant.
   always_comb begin
      w_dist      = 0;
      w_best_dist = NREQ;
      w_best_idx  = 0;
      for (int i = 0; i < NREQ; i++) begin
         w_dist = (i + NREQ - 1 - int'(i_last_grant)) % NREQ;
         if (i_req[i] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            w_best_idx  = i;
         end
      end
   end

   always_comb begin
      o_valid  = (w_best_dist < NREQ);
      o_winner = '0;
      for (int i = 0; i < NREQ; i++) begin
         o_winner[i] = o_valid && (w_best_idx == i);
      end
   end

endmodule

// File: rtl/sd_request_arbiter.sv
// Arbitrates several sector read/write requesters onto one SD controller.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_rd/req_wr       per-requester level requests, held until req_ack
//   req_lba             flat LBA bus, 32 bits per requester
//   req_wr_data         flat write-byte bus, 8 bits per requester
//   req_ack/req_done    one-cycle pulses to the granted requester
//   req_rd_strobe       sd_rd_byte_strobe routed to the granted requester
//   grant               one-hot owner of the SD controller
//   timeout_err         pulse when sd_busy never answered an issue
//   sd_lba/sd_rd/sd_wr/sd_wr_data  request to the SD controller
//   sd_busy/sd_done/sd_rd_byte_strobe  status from the SD controller
//   dbg_state           current FSM state
//
// Handshake: a requester holds req_rd/req_wr until it sees req_ack; the
// arbiter holds sd_rd/sd_wr until it samples sd_busy high, and the transfer
// then runs until sd_done is sampled high. Dropping a request after grant
// does not abort the transfer, and nothing preempts an owner.
module sd_request_arbiter
   import sd_arb_pkg::*;
#(
   parameter int NREQ          = NREQ_DEFAULT,
   parameter int ISSUE_TIMEOUT = ISSUE_TIMEOUT_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_rd,
   input  logic [NREQ-1:0]    req_wr,
   input  logic [NREQ*32-1:0] req_lba,
   input  logic [NREQ*8-1:0]  req_wr_data,
   output logic [NREQ-1:0]    req_ack,
   output logic [NREQ-1:0]    req_done,
   output logic [NREQ-1:0]    req_rd_strobe,
   output logic [NREQ-1:0]    grant,
   output logic               timeout_err,
   output logic [31:0]        sd_lba,
   output logic               sd_rd,
   output logic               sd_wr,
   output logic [7:0]         sd_wr_data,
   input  logic               sd_busy,
   input  logic               sd_done,
   input  logic               sd_rd_byte_strobe,
   output logic [1:0]         dbg_state
);

   localparam int IDXW = idx_width(NREQ);
   localparam int CW   = idx_width(ISSUE_TIMEOUT);

   arb_state_t       r_state,     w_state_nxt;
   logic [NREQ-1:0]  r_grant,     w_grant_nxt;
   logic [IDXW-1:0]  r_gidx,      w_gidx_nxt;
   logic [IDXW-1:0]  r_last,      w_last_nxt;
   logic [31:0]      r_lba,       w_lba_nxt;
   logic             r_sd_rd,     w_sd_rd_nxt;
   logic             r_sd_wr,     w_sd_wr_nxt;
   logic [NREQ-1:0]  r_ack,       w_ack_nxt;
   logic [NREQ-1:0]  r_done,      w_done_nxt;
   logic             r_tmo,       w_tmo_nxt;
   logic [CW-1:0]    r_cnt,       w_cnt_nxt;

   logic [NREQ-1:0]  w_pick;
   logic             w_pick_valid;
   logic [IDXW-1:0]  w_pick_idx;
   logic [31:0]      w_pick_lba;
   logic             w_pick_rd;
   logic             w_pick_wr;
   logic [7:0]       w_wr_data;

   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_rr_pick (
      .i_req        (req_rd | req_wr),
      .i_last_grant (r_last),
      .o_winner     (w_pick),
      .o_valid      (w_pick_valid)
   );

   // Decode the one-hot winner into its index and request fields.
   always_comb begin
      w_pick_idx = '0;
      w_pick_lba = '0;
      w_pick_rd  = 1'b0;
      w_pick_wr  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick[i]) begin
            w_pick_idx = IDXW'(i);
            w_pick_lba = req_lba[32*i +: 32];
            w_pick_rd  = req_rd[i];
            w_pick_wr  = req_wr[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_gidx  <= '0;
         r_last  <= IDXW'(NREQ - 1);
         r_lba   <= '0;
         r_sd_rd <= 1'b0;
         r_sd_wr <= 1'b0;
         r_ack   <= '0;
         r_done  <= '0;
         r_tmo   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_gidx  <= w_gidx_nxt;
         r_last  <= w_last_nxt;
         r_lba   <= w_lba_nxt;
         r_sd_rd <= w_sd_rd_nxt;
         r_sd_wr <= w_sd_wr_nxt;
         r_ack   <= w_ack_nxt;
         r_done  <= w_done_nxt;
         r_tmo   <= w_tmo_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_gidx_nxt  = r_gidx;
      w_last_nxt  = r_last;
      w_lba_nxt   = r_lba;
      w_sd_rd_nxt = r_sd_rd;
      w_sd_wr_nxt = r_sd_wr;
      w_ack_nxt   = '0;
      w_done_nxt  = '0;
      w_tmo_nxt   = 1'b0;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_pick_valid) begin
               w_grant_nxt = w_pick;
               w_gidx_nxt  = w_pick_idx;
               w_lba_nxt   = w_pick_lba;
               // A requester asking for both gets the write.
               w_sd_wr_nxt = w_pick_wr;
               w_sd_rd_nxt = w_pick_rd & ~w_pick_wr;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // sd_done is deliberately not looked at here.
            if (sd_busy) begin
               w_sd_rd_nxt = 1'b0;
               w_sd_wr_nxt = 1'b0;
               w_ack_nxt   = r_grant;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_BUSY;
            end else if (r_cnt == CW'(ISSUE_TIMEOUT - 1)) begin
               w_sd_rd_nxt = 1'b0;
               w_sd_wr_nxt = 1'b0;
               w_grant_nxt = '0;
               w_last_nxt  = r_gidx;
               w_tmo_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_BUSY: begin
            if (sd_done) begin
               w_done_nxt  = r_grant;
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            w_grant_nxt = '0;
            w_last_nxt  = r_gidx;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_wr_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_grant[i]) begin
            w_wr_data = req_wr_data[8*i +: 8];
         end
      end
   end

   assign req_rd_strobe = r_grant & {NREQ{sd_rd_byte_strobe && (r_state == ST_BUSY)}};
   assign req_ack       = r_ack;
   assign req_done      = r_done;
   assign grant         = r_grant;
   assign timeout_err   = r_tmo;
   assign sd_lba        = r_lba;
   assign sd_rd         = r_sd_rd;
   assign sd_wr         = r_sd_wr;
   assign sd_wr_data    = w_wr_data;
   assign dbg_state     = r_state;

endmodule

// File: doc/sd_request_arbiter.md
SD_REQUEST_ARBITER -- requirements
Module: sd_request_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters; slots are 0 = c1541 drive, 1 = loader, 2 = spare.
REQ-002 Parameter ISSUE_TIMEOUT, default 1024: number of cycles allowed for sd_busy to rise after an issue.
REQ-003 clk  in  1  the only clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_rd  in  NREQ  level sector-read request per requester, held until req_ack.
REQ-006 req_wr  in  NREQ  level sector-write request per requester, held until req_ack.
REQ-007 req_lba  in  NREQ*32  flat LBA bus; requester i uses bits [32*i+31:32*i].
REQ-008 req_wr_data  in  NREQ*8  flat write-byte bus; requester i uses bits [8*i+7:8*i].
REQ-009 req_ack  out  NREQ  one-cycle pulse when the SD controller accepts the granted request.
REQ-010 req_done  out  NREQ  one-cycle pulse when the granted transfer completes.
REQ-011 req_rd_strobe  out  NREQ  sd_rd_byte_strobe gated to the granted requester.
REQ-012 grant  out  NREQ  one-hot owner of the SD controller; all zero when idle.
REQ-013 timeout_err  out  1  one-cycle pulse when an issue times out.
REQ-014 sd_lba  out  32  LBA sent to the SD controller.
REQ-015 sd_rd  out  1  read request to the SD controller.
REQ-016 sd_wr  out  1  write request to the SD controller.
REQ-017 sd_wr_data  out  8  write byte taken from the granted requester.
REQ-018 sd_busy  in  1  SD controller has accepted a request.
REQ-019 sd_done  in  1  SD controller transfer has finished.
REQ-020 sd_rd_byte_strobe  in  1  SD controller has a read byte valid.

Function
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, BUSY and RELEASE.
REQ-022 In IDLE, with any req_rd|req_wr bit set, the block SHALL pick round-robin starting from last_grant+1 (mod NREQ); on the next cycle grant is one-hot, sd_lba = the winner's LBA, and the FSM enters ISSUE.
REQ-023 When a requester has both req_rd and req_wr set, write SHALL win: sd_wr=1 and sd_rd=0.
REQ-024 In ISSUE, sd_rd or sd_wr SHALL stay high until sd_busy is sampled high; in that same cycle sd_rd/sd_wr clear, req_ack[g] pulses and the FSM enters BUSY.
REQ-025 In ISSUE, a saturating counter SHALL run; on reaching ISSUE_TIMEOUT-1 without sd_busy, the block pulses timeout_err, clears sd_rd/sd_wr and grant, updates last_grant, and returns to IDLE.
REQ-026 An sd_done arriving while in ISSUE SHALL be ignored.
REQ-027 In BUSY, sd_done high SHALL pulse req_done[g] on the next cycle and move the FSM to RELEASE.
REQ-028 RELEASE SHALL last exactly one cycle: grant clears, last_grant is set to g, and the FSM returns to IDLE, so two back-to-back requests are separated by one idle cycle.
REQ-029 req_rd_strobe[i] SHALL equal sd_rd_byte_strobe & grant[i] & (state==BUSY), combinationally.
REQ-030 sd_wr_data SHALL be the granted requester's byte, and 0 when grant is zero.
REQ-031 sd_lba SHALL be registered at grant and held stable until RELEASE.
REQ-032 Deasserting a request after grant SHALL NOT abort the transfer in progress.
REQ-033 New requests arriving during ISSUE or BUSY SHALL wait; there is no preemption.

Reset
REQ-034 While reset is high, all outputs SHALL be 0, the FSM SHALL be in IDLE, last_grant SHALL be NREQ-1 (so slot 0 wins first), and the timeout counter SHALL be 0; this holds asynchronously, including mid-transfer.
REQ-035 Deassertion of reset SHALL take effect on the first clk edge after reset falls, with no spurious pulse on any output.

Structure
REQ-036 Package sd_arb_pkg SHALL hold the state enum, the NREQ default, the ISSUE_TIMEOUT default, and the requester slot index constants.
REQ-037 The round-robin selection SHALL be one sub-module, rr_pick: combinational, with inputs request vector and last_grant, and outputs a one-hot winner and a valid flag.

Verification
REQ-038 Reset, then req_rd=3'b001 with LBA 0x10; SD raises sd_busy 3 cycles later and sd_done 10 cycles after that -> grant=001, sd_lba=0x10, sd_rd high for 3 cycles, req_ack[0] pulses once, req_done[0] pulses once.
REQ-039 req_rd=3'b111 held continuously -> grants occur in order 001, 010, 100, 001, each separated by exactly one idle cycle.
REQ-040 req_rd[1]=req_wr[1]=1 -> sd_wr=1, sd_rd=0; sd_wr_data equals req_wr_data[15:8].
REQ-041 sd_busy never rises with ISSUE_TIMEOUT=16 -> timeout_err pulses on the 16th ISSUE cycle, grant returns to 0, and the next request goes to the next slot.
REQ-042 sd_rd_byte_strobe pulsed 512 times while slot 2 is granted -> req_rd_strobe[2] shows 512 pulses and slots 0 and 1 show none.
REQ-043 reset asserted mid-BUSY -> outputs are 0 in the same cycle with no clk edge; after release, slot 0 is granted first.
